// File: rtl/pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Hazard detection and pipeline control for a classic 5-stage MIPS-style
// pipeline. Detects load-use hazards, taken branches, jumps, and data-memory
// wait cycles. Drives the PC and IF/ID enables, the IF/ID and ID/EX bubble
// inserts, and the back-end freeze. Also keeps stall/flush performance
// counters and a sticky memory-timeout flag.
//
// Parameters
//   CNT_WIDTH   : width of StallCycles / FlushCount (saturating counters)
//   MEM_TIMEOUT : consecutive busy MEM_WAIT cycles that raise MemTimeout
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   ID_Rs/ID_Rt  in   source registers of the instruction in ID
//   ID_UsesRt    in   ID instruction reads Rt
//   EX_Rt        in   destination register of the instruction in EX
//   EX_MemRead   in   EX instruction is a load
//   BranchTaken  in   branch resolved taken in EX
//   Jump, JR     in   J/JAL or JR decoded in ID
//   MemBusy      in   data memory not ready this cycle
//   PCWrite      out  PC enable
//   IF_ID_Write  out  IF/ID enable
//   IF_ID_Flush  out  bubble into IF/ID
//   ID_EX_Flush  out  bubble into ID/EX
//   PipeFreeze   out  hold ID/EX, EX/MEM, MEM/WB
//   State        out  current FSM state (RUN=0 STALL=1 FLUSH=2 MEM_WAIT=3)
//   StallCycles  out  cycles with PCWrite=0
//   FlushCount   out  cycles with IF_ID_Flush=1
//   MemTimeout   out  sticky memory-timeout error
//
// Control outputs are Mealy (combinational from state and inputs); state,
// counters and MemTimeout are registered. Outputs carry no handshake: they
// are plain per-cycle enables, valid whenever clk is running.
// ---------------------------------------------------------------------------
module pipeline_hazard_unit #(
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           ID_Rs,
    input  logic [4:0]           ID_Rt,
    input  logic                 ID_UsesRt,
    input  logic [4:0]           EX_Rt,
    input  logic                 EX_MemRead,
    input  logic                 BranchTaken,
    input  logic                 Jump,
    input  logic                 JR,
    input  logic                 MemBusy,
    output logic                 PCWrite,
    output logic                 IF_ID_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Flush,
    output logic                 PipeFreeze,
    output logic [1:0]           State,
    output logic [CNT_WIDTH-1:0] StallCycles,
    output logic [CNT_WIDTH-1:0] FlushCount,
    output logic                 MemTimeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    // Wait counter only needs to reach MEM_TIMEOUT, where it saturates.
    localparam int              WAIT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t                r_state;
    state_t                w_next_state;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [WAIT_W-1:0]     w_wait_inc;
    logic [CNT_WIDTH-1:0]  r_stall_cycles;
    logic [CNT_WIDTH-1:0]  r_flush_count;
    logic                  r_mem_timeout;

    logic                  w_load_use;
    logic                  w_lu_allowed;
    logic                  w_jump_any;
    logic                  w_busy_wait;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                        ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    // After a stall or a flush the EX stage holds a bubble, so any load-use
    // match seen there is against stale EX fields and must be ignored.
    // MEM_WAIT released behaves exactly like RUN.
    assign w_lu_allowed = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);

    assign w_jump_any  = Jump || JR;
    assign w_busy_wait = (r_state == ST_MEM_WAIT) && MemBusy;

    // ------------------------------------------------------------------
    // Next-state and Mealy outputs
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        PipeFreeze   = 1'b0;
        w_next_state = ST_RUN;

        if (reset) begin
            // Hold fetch and squash both front registers while in reset.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            PipeFreeze   = 1'b0;
            w_next_state = ST_RUN;
        end else if (MemBusy) begin
            // Memory stall outranks everything in every state. In MEM_WAIT
            // this also covers "ignore all other events and stay".
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            PipeFreeze   = 1'b1;
            w_next_state = ST_MEM_WAIT;
        end else if (BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            w_next_state = ST_FLUSH;
        end else if (w_jump_any) begin
            IF_ID_Flush  = 1'b1;
            w_next_state = ST_RUN;
        end else if (w_load_use && w_lu_allowed) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
            w_next_state = ST_STALL;
        end else begin
            w_next_state = ST_RUN;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Memory wait counter and sticky timeout
    // ------------------------------------------------------------------
    assign w_wait_inc = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : (r_wait_cnt + WAIT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_busy_wait) begin
                r_wait_cnt <= w_wait_inc;
                // Flag goes up on the edge that closes the MEM_TIMEOUT-th
                // consecutive busy cycle.
                if (w_wait_inc == WAIT_MAX) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                // Either not waiting or leaving MEM_WAIT this cycle.
                r_wait_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (saturating at all-ones)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!PCWrite && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if (IF_ID_Flush && (r_flush_count != {CNT_WIDTH{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_WIDTH'(1);
            end
        end
    end

    assign State       = r_state;
    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;
    assign MemTimeout  = r_mem_timeout;

    // ------------------------------------------------------------------
    // Structural invariants of the control encoding
    // ------------------------------------------------------------------
    a_enables_match: assert property (@(posedge clk) disable iff (reset)
        PCWrite == IF_ID_Write);
    a_freeze_holds_pc: assert property (@(posedge clk) disable iff (reset)
        PipeFreeze |-> !PCWrite);
    a_flush_keeps_fetch: assert property (@(posedge clk) disable iff (reset)
        IF_ID_Flush |-> PCWrite);

endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-002 Parameter MEM_TIMEOUT, default 255: consecutive memory-wait cycles that trigger the timeout.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
REQ-007 ID_UsesRt  in  1  the ID instruction reads Rt (R-type, BEQ, BNE, SW).
REQ-008 EX_Rt  in  5  destination register of the instruction in EX.
REQ-009 EX_MemRead  in  1  the EX instruction is a LW.
REQ-010 BranchTaken  in  1  branch resolved taken in EX.
REQ-011 Jump, JR  in  1 each  J/JAL or JR decoded in ID.
REQ-012 MemBusy  in  1  data memory not ready this cycle.
REQ-013 PCWrite, IF_ID_Write  out  1 each  PC and IF/ID register enables.
REQ-014 IF_ID_Flush, ID_EX_Flush  out  1 each  insert a bubble into that register.
REQ-015 PipeFreeze  out  1  hold the ID/EX, EX/MEM and MEM/WB registers.
REQ-016 State  out  2  current FSM state.
REQ-017 StallCycles, FlushCount  out  CNT_WIDTH each  performance counters.
REQ-018 MemTimeout  out  1  sticky memory-timeout error.

Function
REQ-019 The FSM SHALL have four states: RUN=0, STALL=1, FLUSH=2, MEM_WAIT=3.
REQ-020 Control outputs SHALL be combinational from the state and inputs (Mealy); the state, counters and MemTimeout SHALL be registered.
REQ-021 Default (no event): PCWrite=1, IF_ID_Write=1, flushes=0, PipeFreeze=0.
REQ-022 LoadUse SHALL be EX_MemRead & (EX_Rt!=0) & ((EX_Rt==ID_Rs) | (ID_UsesRt & EX_Rt==ID_Rt)).
REQ-023 In RUN, STALL and FLUSH, events SHALL be evaluated in priority order MemBusy > BranchTaken > Jump|JR > LoadUse.
- MemBusy: PCWrite=0, IF_ID_Write=0, PipeFreeze=1; next state MEM_WAIT.
- BranchTaken: IF_ID_Flush=1, ID_EX_Flush=1; next state FLUSH.
- Jump|JR: IF_ID_Flush=1; next state RUN.
- LoadUse: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next state STALL.
- No event: next state RUN.
REQ-024 In STALL and FLUSH, LoadUse SHALL be ignored, because EX holds a bubble.
REQ-025 In MEM_WAIT with MemBusy=1, the unit SHALL hold freeze outputs as in REQ-023, assert no flush, ignore all other events, and remain in MEM_WAIT.
REQ-026 In MEM_WAIT with MemBusy=0, outputs and next state SHALL follow the RUN rules in the same cycle, with no extra penalty cycle.
REQ-027 A wait counter SHALL count consecutive cycles spent in MEM_WAIT with MemBusy=1.
- The counter SHALL clear on leaving MEM_WAIT.
- When it reaches MEM_TIMEOUT, MemTimeout SHALL set and remain 1 until reset.
- The counter SHALL saturate at MEM_TIMEOUT.
REQ-028 StallCycles SHALL increment on every non-reset cycle with PCWrite=0, saturating at all-ones.
REQ-029 FlushCount SHALL increment on every non-reset cycle with IF_ID_Flush=1, saturating at all-ones.
REQ-030 Simultaneous events SHALL follow the REQ-023 priority.
- BranchTaken with Jump or LoadUse: the branch wins, no stall is asserted, and the counters record only the flush.

Reset
REQ-031 While reset=1, outputs SHALL be forced to PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, PipeFreeze=0.
REQ-032 At the next clock edge after reset is sampled, the unit SHALL set State=RUN, StallCycles=0, FlushCount=0, MemTimeout=0 and wait counter=0.
REQ-033 Reset SHALL take effect mid-stall or mid-wait, with no residual freeze after reset deasserts.

Verification
REQ-034 Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8 in RUN -> one cycle of PCWrite=0 and ID_EX_Flush=1, then State=STALL with default outputs; StallCycles=1.
REQ-035 Zero register: EX_MemRead=1, EX_Rt=0, ID_Rs=0 -> no stall; ID_UsesRt=0 with EX_Rt==ID_Rt=9 -> no stall.
REQ-036 Branch over jump and load-use: BranchTaken=1, Jump=1 and a LoadUse condition together -> both flushes=1, PCWrite=1, next State=FLUSH; FlushCount+1, StallCycles unchanged.
REQ-037 Memory wait: MemBusy held 3 cycles -> PipeFreeze=1 for 3 cycles and State=MEM_WAIT; on the cycle MemBusy drops, default outputs are driven; StallCycles=3.
REQ-038 Timeout: MEM_TIMEOUT=4, MemBusy held 6 cycles -> MemTimeout rises after the 4th MEM_WAIT cycle and stays 1 after MemBusy drops, until reset.
REQ-039 Reset mid-wait: reset pulsed during MEM_WAIT -> reset outputs per REQ-031; next cycle State=RUN, all counters 0, MemTimeout=0.
